// File: rtl/audio_mix_if.sv
// Sample-stream bundle between the channel sources, the mixer and the downstream sink.
// The master side owns the channel data/valid and the output ready; the slave is the mixer.
interface audio_mix_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 24
);
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH-1:0]        ch_ready;
  logic [DATA_W-1:0]        mix_data;
  logic                     mix_valid;
  logic                     mix_ready;

  modport master (
    output ch_data, ch_valid, mix_ready,
    input  ch_ready, mix_data, mix_valid
  );

  modport slave (
    input  ch_data, ch_valid, mix_ready,
    output ch_ready, mix_data, mix_valid
  );
endinterface

// File: rtl/audio_mix_sequencer.sv
// Time-multiplexed audio mixer: one multiply-accumulate unit walks every channel per frame,
// then clamps the sum to the sample range and offers it downstream with a valid/ready handshake.
module audio_mix_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 24,
  parameter int GAIN_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     frame_tick,
  audio_mix_if.slave               bus,
  input  logic [NUM_CH*GAIN_W-1:0] gain,
  input  logic [NUM_CH-1:0]        ch_enable,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout_err,
  output logic [15:0]              sat_count,
  input  logic                     stat_clr
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int ACC_W  = PROD_W + 2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] MAC   = 3'd2;
  localparam logic [2:0] SAT   = 3'd3;
  localparam logic [2:0] OUT   = 3'd4;

  // Q1.15 scaling: the shift floors toward minus infinity, matching the arithmetic shift.
  function automatic logic signed [ACC_W-1:0] scale_product(
    input logic signed [DATA_W-1:0] s,
    input logic signed [GAIN_W-1:0] g
  );
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] q;
    p = PROD_W'(s) * PROD_W'(g);
    q = p >>> (GAIN_W - 1);
    return {{(ACC_W-PROD_W){q[PROD_W-1]}}, q};
  endfunction

  function automatic logic clips(input logic signed [ACC_W-1:0] a);
    return (a > MAX_V) || (a < MIN_V);
  endfunction

  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > MAX_V)      return MAX_V[DATA_W-1:0];
    else if (a < MIN_V) return MIN_V[DATA_W-1:0];
    else                return a[DATA_W-1:0];
  endfunction

  logic [2:0]                state;
  logic [IDX_W-1:0]          idx;
  logic [TMR_W-1:0]          timer;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         mix_data_q;
  logic signed [DATA_W-1:0]  sample_p0;
  logic signed [GAIN_W-1:0]  gain_q [NUM_CH];
  logic [NUM_CH-1:0]         en_q;
  logic signed [DATA_W-1:0]  chan_sample [NUM_CH];
  logic [NUM_CH-1:0]         ready_int;
  logic                      sat_evt;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) chan_sample[i] = bus.ch_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    ready_int = '0;
    if (state == FETCH && en_q[idx]) ready_int[idx] = 1'b1;
  end

  assign sat_evt       = (state == SAT) && clips(acc);
  assign bus.ch_ready  = ready_int;
  assign bus.mix_data  = mix_data_q;
  assign bus.mix_valid = (state == OUT);
  assign busy          = (state != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      acc         <= '0;
      mix_data_q  <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      sat_count   <= '0;
    end else begin
      overrun     <= frame_tick && (state != IDLE);
      timeout_err <= 1'b0;

      if (stat_clr)                                sat_count <= '0;
      else if (sat_evt && sat_count != 16'hFFFF)   sat_count <= sat_count + 16'd1;

      case (state)
        IDLE: begin
          if (frame_tick) begin
            state <= FETCH;
            idx   <= '0;
            timer <= '0;
            acc   <= '0;
          end
        end
        FETCH: begin
          if (!en_q[idx]) begin
            if (idx == LAST_IDX) state <= SAT;
            else                 idx   <= idx + 1'b1;
          end else if (bus.ch_valid[idx]) begin
            state <= MAC;
            timer <= '0;
          end else if (timer == TMR_LAST) begin
            state       <= MAC;
            timer       <= '0;
            timeout_err <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        MAC: begin
          acc <= acc + scale_product(sample_p0, gain_q[idx]);
          if (idx == LAST_IDX) begin
            state <= SAT;
          end else begin
            state <= FETCH;
            idx   <= idx + 1'b1;
          end
        end
        SAT: begin
          mix_data_q <= saturate(acc);
          state      <= OUT;
        end
        OUT: begin
          if (bus.mix_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Frame snapshot and sample capture; a channel that times out contributes a zero sample.
  always_ff @(posedge ACLK) begin
    if (!ARESET && state == IDLE && frame_tick) begin
      for (int i = 0; i < NUM_CH; i++) gain_q[i] <= gain[i*GAIN_W +: GAIN_W];
      en_q <= ch_enable;
    end
    if (state == FETCH) begin
      sample_p0 <= (en_q[idx] && bus.ch_valid[idx]) ? chan_sample[idx] : '0;
    end
  end

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Randomized scoreboard bench for the audio mixer: a stimulus thread queues the expected
// mix result and its arrival cycle; a monitor pops and compares whenever an output is taken.
module tb_audio_mix_sequencer;
  localparam int NCH = 4;
  localparam int DW  = 24;
  localparam int GW  = 16;
  localparam int TO  = 64;
  localparam longint MAXS = 64'sd8388607;
  localparam longint MINS = -64'sd8388608;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  logic frame_tick = 1'b0;
  logic stat_clr = 1'b0;
  logic [NCH*GW-1:0] gain = '0;
  logic [NCH-1:0] ch_enable = '0;
  logic busy, overrun, timeout_err;
  logic [15:0] sat_count;

  audio_mix_if #(.NUM_CH(NCH), .DATA_W(DW)) bus ();

  audio_mix_sequencer #(.NUM_CH(NCH), .DATA_W(DW), .GAIN_W(GW), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .frame_tick(frame_tick), .bus(bus),
    .gain(gain), .ch_enable(ch_enable), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .sat_count(sat_count), .stat_clr(stat_clr)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  int ovr_cnt = 0, ovr_cyc = 0, to_cnt = 0, onehot_bad = 0, exp_to = 0;
  logic [NCH-1:0] ever_ready = '0;
  logic [DW-1:0] held = '0;
  bit prev_v = 1'b0;
  logic [15:0] sat_model = '0;
  int rdy_mode = 0;

  logic [DW-1:0] cfg_sample [NCH];
  logic [GW-1:0] cfg_gain [NCH];
  logic [NCH-1:0] cfg_en = '0;
  int cfg_delay [NCH];
  bit cfg_never [NCH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Channel sources and downstream sink; delay 0 means valid held high throughout.
  initial begin : drv
    int streak [NCH];
    for (int i = 0; i < NCH; i++) begin
      streak[i] = 0; cfg_delay[i] = 0; cfg_never[i] = 1'b0; cfg_sample[i] = '0; cfg_gain[i] = '0;
    end
    bus.ch_data = '0;
    bus.ch_valid = '0;
    bus.mix_ready = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      for (int i = 0; i < NCH; i++) begin
        if (cfg_never[i])        bus.ch_valid[i] = 1'b0;
        else if (cfg_delay[i] == 0) bus.ch_valid[i] = 1'b1;
        else bus.ch_valid[i] = bus.ch_ready[i] && (streak[i] >= cfg_delay[i]);
        streak[i] = bus.ch_ready[i] ? streak[i] + 1 : 0;
      end
      case (rdy_mode)
        0:       bus.mix_ready = 1'b1;
        1:       bus.mix_ready = 1'($urandom_range(0, 1));
        default: bus.mix_ready = 1'b0;
      endcase
    end
  end

  always @(negedge ACLK) begin
    exp_t e;
    if (bus.mix_valid === 1'b1) begin
      if (!prev_v) begin
        held = bus.mix_data;
        if (exp_q.size() > 0) check("latency", 64'(cyc), 64'(exp_q[0].due));
      end else begin
        check("hold_stable", 64'(bus.mix_data), 64'(held));
      end
      if (bus.mix_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got data 0x%0h, expected no output (cycle %0d)", bus.mix_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("mix_data", 64'(bus.mix_data), 64'(e.data));
        end
        n_out++;
      end
    end
    prev_v = (bus.mix_valid === 1'b1) && !bus.mix_ready;
    if (overrun === 1'b1) begin ovr_cnt++; ovr_cyc = cyc; end
    if (timeout_err === 1'b1) to_cnt++;
    ever_ready = ever_ready | bus.ch_ready;
    if ($countones(bus.ch_ready) > 1) onehot_bad++;
  end

  task automatic set_uniform(input logic [DW-1:0] s, input logic [GW-1:0] g,
                             input logic [NCH-1:0] en, input int d);
    for (int i = 0; i < NCH; i++) begin
      cfg_sample[i] = s; cfg_gain[i] = g; cfg_delay[i] = d; cfg_never[i] = 1'b0;
    end
    cfg_en = en;
  endtask

  // Issues one frame_tick and, from the frame rules, predicts the output and its arrival cycle.
  task automatic launch(input bit push, output int t_tick);
    longint acc, p, q, clamped;
    int lat;
    bit sat;
    exp_t e;
    @(posedge ACLK); #1;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_data[i*DW +: DW] = cfg_sample[i];
      gain[i*GW +: GW] = cfg_gain[i];
    end
    ch_enable = cfg_en;
    frame_tick = 1'b1;
    t_tick = cyc;
    ovr_cnt = 0; to_cnt = 0; onehot_bad = 0; ever_ready = '0;
    acc = 0; lat = 2; exp_to = 0;
    for (int i = 0; i < NCH; i++) begin
      if (!cfg_en[i]) begin
        lat += 1;
      end else if (cfg_never[i]) begin
        lat += TO + 1;
        exp_to++;
      end else begin
        p = longint'($signed(cfg_sample[i])) * longint'($signed(cfg_gain[i]));
        q = p / 32768;
        if (p < 0 && (p % 32768) != 0) q = q - 1;
        acc += q;
        lat += cfg_delay[i] + 2;
      end
    end
    sat = 1'b0;
    clamped = acc;
    if (acc > MAXS) begin clamped = MAXS; sat = 1'b1; end
    if (acc < MINS) begin clamped = MINS; sat = 1'b1; end
    e.data = clamped[DW-1:0];
    e.due = t_tick + lat;
    if (push) begin
      exp_q.push_back(e);
      if (sat && sat_model != 16'hFFFF) sat_model = sat_model + 16'd1;
    end
    @(posedge ACLK); #1;
    frame_tick = 1'b0;
    gain = {$urandom, $urandom};
    ch_enable = NCH'($urandom);
  endtask

  task automatic wait_out(input int target);
    int budget = 0;
    while (n_out < target && budget < 600) begin
      @(posedge ACLK); #1;
      budget++;
    end
    check("frame_done", 64'(n_out), 64'(target));
    if (n_out < target) exp_q.delete();
    repeat (2) begin @(posedge ACLK); #1; end
  endtask

  task automatic end_check(input int exp_ovr);
    check("sat_count", 64'(sat_count), 64'(sat_model));
    check("overrun_pulses", 64'(ovr_cnt), 64'(exp_ovr));
    check("timeout_pulses", 64'(to_cnt), 64'(exp_to));
    check("ready_mask", 64'(ever_ready), 64'(cfg_en));
    check("ready_onehot", 64'(onehot_bad), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic std_frame();
    int t, tgt;
    tgt = n_out + 1;
    launch(1'b1, t);
    wait_out(tgt);
    end_check(0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mix_valid"}, 64'(bus.mix_valid), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_ch_ready"}, 64'(bus.ch_ready), 64'(0));
    check({tag, "_mix_data"}, 64'(bus.mix_data), 64'(0));
    check({tag, "_sat_count"}, 64'(sat_count), 64'(0));
    check({tag, "_overrun"}, 64'(overrun), 64'(0));
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, tgt, b;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_quiet("reset");
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (2) begin @(posedge ACLK); #1; end

    // Unity-gain path, then positive and negative saturation, then the -1 * -1 corner.
    set_uniform(24'h100000, 16'h4000, 4'hF, 0);  std_frame();
    set_uniform(24'h7FFFFF, 16'h7FFF, 4'hF, 0);  std_frame();
    set_uniform(24'h800000, 16'h7FFF, 4'hF, 0);  std_frame();
    set_uniform(24'h800000, 16'h8000, 4'b0001, 0); std_frame();

    // All muted, then a muted channel that never offers data, then a timed-out channel.
    set_uniform(24'h123456, 16'h1234, 4'h0, 0);  std_frame();
    set_uniform(24'h0A0B0C, 16'h3000, 4'b0101, 2); cfg_never[1] = 1'b1; std_frame();
    set_uniform(24'hF00001, 16'h5000, 4'hF, 1);  cfg_never[2] = 1'b1; std_frame();

    // Backpressure with a second tick arriving while the result is held.
    set_uniform(24'h012345, 16'h2000, 4'hF, 0);
    rdy_mode = 2;
    tgt = n_out + 1;
    launch(1'b1, t);
    b = 0;
    while (bus.mix_valid !== 1'b1 && b < 100) begin @(posedge ACLK); #1; b++; end
    repeat (5) begin @(posedge ACLK); #1; end
    frame_tick = 1'b1;
    t2 = cyc;
    @(posedge ACLK); #1;
    frame_tick = 1'b0;
    repeat (14) begin @(posedge ACLK); #1; end
    rdy_mode = 0;
    wait_out(tgt);
    end_check(1);
    check("overrun_cycle", 64'(ovr_cyc), 64'(t2 + 1));
    repeat (15) begin @(posedge ACLK); #1; end
    check("single_output", 64'(n_out), 64'(tgt));
    check("busy_after_bp", 64'(busy), 64'(0));

    // Reset during the first MAC abandons the frame.
    set_uniform(24'h7FFFFF, 16'h7FFF, 4'hF, 0);
    tgt = n_out;
    launch(1'b0, t);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    sat_model = '0;
    @(negedge ACLK);
    check_quiet("midreset");
    repeat (12) begin @(posedge ACLK); #1; end
    check("abandoned_frame", 64'(n_out), 64'(tgt));
    set_uniform(24'h200000, 16'h4000, 4'b1011, 0); std_frame();

    // Clear request landing on the same edge as a saturation increment.
    set_uniform(24'h7FFFFF, 16'h7FFF, 4'hF, 0);  std_frame();
    tgt = n_out + 1;
    launch(1'b1, t);
    while (cyc < t + 9) begin @(posedge ACLK); #1; end
    stat_clr = 1'b1;
    @(posedge ACLK); #1;
    stat_clr = 1'b0;
    sat_model = '0;
    @(negedge ACLK);
    check("clear_wins", 64'(sat_count), 64'(0));
    wait_out(tgt);
    end_check(0);

    // Tick coincident with reset is ignored.
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    frame_tick = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    frame_tick = 1'b0;
    tgt = n_out;
    repeat (12) begin
      @(negedge ACLK);
      check("tick_in_reset_busy", 64'(busy), 64'(0));
    end
    check("tick_in_reset_no_out", 64'(n_out), 64'(tgt));
    set_uniform(24'hFFF000, 16'hC000, 4'hF, 0);  std_frame();

    // Randomized frames with random enables, source delays, dropouts and sink backpressure.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NCH; i++) begin
        cfg_sample[i] = DW'($urandom);
        case ($urandom_range(0, 7))
          0:       cfg_gain[i] = 16'h8000;
          1:       cfg_gain[i] = 16'h7FFF;
          default: cfg_gain[i] = GW'($urandom);
        endcase
        cfg_delay[i] = $urandom_range(0, 4);
        cfg_never[i] = ($urandom_range(0, 9) == 0);
      end
      cfg_en = NCH'($urandom);
      rdy_mode = $urandom_range(0, 1);
      std_frame();
      repeat ($urandom_range(0, 3)) begin @(posedge ACLK); #1; end
    end
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_mix_sequencer.md
AUDIO_MIX_SEQUENCER -- requirements
Module: audio_mix_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of input channels sharing the single multiply-accumulate datapath.
REQ-002 SHALL have parameter DATA_W, default 24, meaning the signed two's-complement sample width.
REQ-003 SHALL have parameter GAIN_W, default 16, meaning the signed Q1.15 gain width.
REQ-004 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for a channel sample.
REQ-005 SHALL have port ACLK, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port ARESET, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port frame_tick, input, 1: one-cycle sample-period start pulse.
REQ-008 SHALL have port ch_data, input, NUM_CH*DATA_W: channel samples, channel i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port ch_valid, input, NUM_CH: per-channel sample valid.
REQ-010 SHALL have port ch_ready, output, NUM_CH: per-channel sample accept.
REQ-011 SHALL have port gain, input, NUM_CH*GAIN_W: per-channel gain, packed like ch_data, driven from the AXI4-Lite register bank.
REQ-012 SHALL have port ch_enable, input, NUM_CH: channel enable mask; 0 means muted and skipped.
REQ-013 SHALL have port mix_data, output, DATA_W: mixed, saturated output sample.
REQ-014 SHALL have port mix_valid, output, 1: output sample valid.
REQ-015 SHALL have port mix_ready, input, 1: downstream accept.
REQ-016 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-017 SHALL have port overrun, output, 1: one-cycle pulse.
REQ-018 SHALL have port timeout_err, output, 1: one-cycle pulse.
REQ-019 SHALL have port sat_count, output, 16: saturation event counter.
REQ-020 SHALL have port stat_clr, input, 1: synchronous clear of sat_count.

Function
REQ-021 SHALL implement states IDLE, FETCH, MAC, SAT and OUT, with channel index idx ranging over 0..NUM_CH-1.
REQ-022 IDLE + frame_tick SHALL go to FETCH with idx=0, clear the accumulator, and snapshot gain and ch_enable for the whole frame.
REQ-023 In FETCH with the channel disabled, ch_ready SHALL stay low and the next state SHALL be FETCH(idx+1), or SAT if idx=NUM_CH-1.
REQ-024 In FETCH with the channel enabled, ch_ready[idx] SHALL be high (all other ch_ready bits low); on ch_valid[idx] the sample SHALL be captured and the next state SHALL be MAC.
REQ-025 If an enabled channel shows no ch_valid for TIMEOUT consecutive FETCH cycles, the sample SHALL be taken as 0, timeout_err SHALL pulse, ch_ready SHALL drop, and the next state SHALL be MAC.
REQ-026 MAC SHALL compute acc += (sample*gain)>>>15 with a 40-bit signed product, arithmetic shift (floor), and a 42-bit accumulator; the next state SHALL be FETCH(idx+1), or SAT after the last channel.
REQ-027 SAT SHALL clamp acc to [-2^23, 2^23-1] into mix_data; if clamping occurs, sat_count SHALL increment, saturating at 0xFFFF; the next state SHALL be OUT.
REQ-028 In OUT, mix_valid SHALL be high and mix_data SHALL be held stable until mix_ready; on the handshake the next state SHALL be IDLE.
REQ-029 With all channels enabled and valid held high, tick at cycle T SHALL give mix_valid at T+2*NUM_CH+2 (T+10 for the defaults); with all channels disabled, mix_valid SHALL occur at T+NUM_CH+2 with mix_data=0.
REQ-030 frame_tick while not IDLE SHALL be ignored and SHALL pulse overrun in the following cycle; the current frame SHALL continue unaffected.
REQ-031 stat_clr simultaneous with a saturation increment SHALL leave sat_count at 0 (clear wins).
REQ-032 gain = -2^15 with sample = -2^23 SHALL yield +2^23, which then saturates to 0x7FFFFF.

Reset
REQ-033 ARESET SHALL force state IDLE, idx 0, accumulator 0, ch_ready 0, mix_data 0, mix_valid 0, busy 0, overrun 0, timeout_err 0, and sat_count 0 on the next edge.
REQ-034 Reset asserted mid-frame SHALL abandon the frame: no mix_valid for that frame, and ch_ready low from the next cycle.
REQ-035 frame_tick coincident with ARESET SHALL be ignored.

Verification
REQ-036 Unity path: 4 channels enabled, gain 0x4000 (0.5) each, samples 0x100000 each, mix_ready=1 -> mix_data=0x200000 at T+10, sat_count=0.
REQ-037 Saturation: gain 0x7FFF each, samples 0x7FFFFF each -> mix_data=0x7FFFFF, sat_count=1; repeated with samples 0x800000 -> 0x800000, sat_count=2.
REQ-038 Mute and timeout: ch_enable=4'b0101, ch1 never valid -> ch_ready[1] never asserted; with ch_enable=4'hF and ch2 never valid -> timeout_err pulse after 64 FETCH cycles and ch2 contributes 0.
REQ-039 Backpressure and overrun: mix_ready=0 for 20 cycles plus a second frame_tick during OUT -> mix_data stable, overrun pulse one cycle, one output only.
REQ-040 Reset mid-MAC and stat_clr coincident with saturation -> all outputs 0 next cycle, sat_count=0, new frame_tick processes normally.
